// File: rtl/mem_pkg.sv
// Shared types and constants for the BRAM access controller and its
// load/store alignment helper.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WRITE    = 3'd3,
      RESP     = 3'd4
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // A full-word store can skip the read half of read-modify-write.
   function automatic logic is_word_store(input logic we, input logic [2:0] funct3);
      return we && (funct3 == F3_W);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load extraction/extension, sub-word store merge and
// misalignment / illegal-funct3 detection.
module lsu_align
   import mem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic        err,
   output logic [31:0] load_data,
   output logic [31:0] merged_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        illegal_s;
   logic        misaligned_s;

   // Byte and halfword lanes selected by the low address bits.
   always_comb begin
      byte_s = 8'h00;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Stores accept only B/H/W; loads additionally accept BU/HU.
   always_comb begin
      illegal_s = 1'b1;
      case (funct3)
         F3_B, F3_H, F3_W: illegal_s = 1'b0;
         F3_BU, F3_HU:     illegal_s = we;
         default:          illegal_s = 1'b1;
      endcase
      misaligned_s = 1'b0;
      case (funct3[1:0])
         2'b00:   misaligned_s = 1'b0;
         2'b01:   misaligned_s = addr_lo[0];
         2'b10:   misaligned_s = (addr_lo != 2'b00);
         default: misaligned_s = 1'b0;
      endcase
      err = illegal_s || misaligned_s;
   end

   // Load result extension.
   always_comb begin
      load_data = 32'h0000_0000;
      case (funct3)
         F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
         F3_BU:   load_data = {24'h00_0000, byte_s};
         F3_H:    load_data = {{16{half_s[15]}}, half_s};
         F3_HU:   load_data = {16'h0000, half_s};
         F3_W:    load_data = rdata;
         default: load_data = 32'h0000_0000;
      endcase
   end

   // Sub-word store merge into the word just read back.
   always_comb begin
      merged_data = rdata;
      case (funct3[1:0])
         2'b00: begin
            case (addr_lo)
               2'd0:    merged_data[7:0]   = wdata[7:0];
               2'd1:    merged_data[15:8]  = wdata[7:0];
               2'd2:    merged_data[23:16] = wdata[7:0];
               2'd3:    merged_data[31:24] = wdata[7:0];
               default: merged_data = rdata;
            endcase
         end
         2'b01: begin
            if (addr_lo[1]) begin
               merged_data[31:16] = wdata[15:0];
            end else begin
               merged_data[15:0] = wdata[15:0];
            end
         end
         default: merged_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Round-robin arbiter and access sequencer sharing one simple-dual-port
// BRAM between instruction fetch and load/store; one access in flight.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req_valid,
   input  logic [31:0]       i_req_addr,
   output logic              i_req_ready,
   output logic              i_resp_valid,
   output logic [31:0]       i_resp_data,
   output logic              i_resp_err,
   input  logic              d_req_valid,
   input  logic              d_req_we,
   input  logic [31:0]       d_req_addr,
   input  logic [31:0]       d_req_wdata,
   input  logic [2:0]        d_req_funct3,
   output logic              d_req_ready,
   output logic              d_resp_valid,
   output logic [31:0]       d_resp_rdata,
   output logic              d_resp_err,
   output logic              mem_read_enable,
   output logic [ADDR_W-1:0] mem_addr_read,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_addr_write,
   output logic [31:0]       mem_data_in,
   input  logic [31:0]       mem_data_out
);

   state_t            state_r, state_s;
   owner_t            last_grant_r, last_grant_s;
   owner_t            owner_r, owner_s;
   logic [ADDR_W+1:0] addr_r, addr_s;
   logic              we_r, we_s;
   logic [31:0]       wdata_r, wdata_s;
   logic [2:0]        funct3_r, funct3_s;
   logic [31:0]       data_r, data_s;
   logic              err_r, err_s;

   logic              grant_fetch_s, grant_data_s;
   logic              al_we_s;
   logic [2:0]        al_funct3_s;
   logic [ADDR_W+1:0] al_addr_s;
   logic [31:0]       al_wdata_s;
   logic              al_err_s;
   logic [31:0]       al_load_s, al_merged_s;
   logic              active_s;
   logic              unused_addr_s;

   assign active_s      = !reset;
   assign unused_addr_s = ^{i_req_addr[31:ADDR_W+2], d_req_addr[31:ADDR_W+2]};

   // Round-robin grant, only while idle; the loser of a tie won last time.
   always_comb begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
      if ((state_r == IDLE) && active_s) begin
         if (i_req_valid && d_req_valid) begin
            if (last_grant_r == DATA) begin
               grant_fetch_s = 1'b1;
            end else begin
               grant_data_s = 1'b1;
            end
         end else begin
            grant_fetch_s = i_req_valid;
            grant_data_s  = d_req_valid;
         end
      end else begin
         grant_fetch_s = 1'b0;
         grant_data_s  = 1'b0;
      end
   end

   // Alignment unit sees the incoming request while idle, latched fields otherwise.
   always_comb begin
      al_we_s     = we_r;
      al_funct3_s = funct3_r;
      al_addr_s   = addr_r;
      al_wdata_s  = wdata_r;
      if (state_r == IDLE) begin
         if (grant_fetch_s) begin
            al_we_s     = 1'b0;
            al_funct3_s = F3_W;
            al_addr_s   = i_req_addr[ADDR_W+1:0];
            al_wdata_s  = 32'h0000_0000;
         end else begin
            al_we_s     = d_req_we;
            al_funct3_s = d_req_funct3;
            al_addr_s   = d_req_addr[ADDR_W+1:0];
            al_wdata_s  = d_req_wdata;
         end
      end else begin
         al_we_s = we_r;
      end
   end

   lsu_align u_align (
      .we          (al_we_s),
      .funct3      (al_funct3_s),
      .addr_lo     (al_addr_s[1:0]),
      .rdata       (mem_data_out),
      .wdata       (al_wdata_s),
      .err         (al_err_s),
      .load_data   (al_load_s),
      .merged_data (al_merged_s)
   );

   // Next-state and datapath update.
   always_comb begin
      state_s      = state_r;
      last_grant_s = last_grant_r;
      owner_s      = owner_r;
      addr_s       = addr_r;
      we_s         = we_r;
      wdata_s      = wdata_r;
      funct3_s     = funct3_r;
      data_s       = data_r;
      err_s        = err_r;
      case (state_r)
         IDLE: begin
            if (grant_fetch_s || grant_data_s) begin
               owner_s      = grant_fetch_s ? FETCH : DATA;
               last_grant_s = grant_fetch_s ? FETCH : DATA;
               addr_s       = al_addr_s;
               we_s         = al_we_s;
               wdata_s      = al_wdata_s;
               funct3_s     = al_funct3_s;
               data_s       = 32'h0000_0000;
               err_s        = al_err_s;
               if (al_err_s) begin
                  state_s = RESP;
               end else if (is_word_store(al_we_s, al_funct3_s)) begin
                  state_s = WRITE;
               end else begin
                  state_s = RD_ISSUE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RD_ISSUE: state_s = RD_WAIT;
         RD_WAIT: begin
            if (we_r) begin
               data_s  = al_merged_s;
               state_s = WRITE;
            end else begin
               data_s  = al_load_s;
               state_s = RESP;
            end
         end
         WRITE: begin
            data_s  = 32'h0000_0000;
            state_s = RESP;
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and request registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= IDLE;
         last_grant_r <= DATA;
         owner_r      <= FETCH;
         addr_r       <= {(ADDR_W+2){1'b0}};
         we_r         <= 1'b0;
         wdata_r      <= 32'h0000_0000;
         funct3_r     <= 3'b000;
         data_r       <= 32'h0000_0000;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_s;
         last_grant_r <= last_grant_s;
         owner_r      <= owner_s;
         addr_r       <= addr_s;
         we_r         <= we_s;
         wdata_r      <= wdata_s;
         funct3_r     <= funct3_s;
         data_r       <= data_s;
         err_r        <= err_s;
      end
   end

   assign i_req_ready  = grant_fetch_s;
   assign d_req_ready  = grant_data_s;

   assign i_resp_valid = active_s && (state_r == RESP) && (owner_r == FETCH);
   assign i_resp_data  = i_resp_valid ? data_r : 32'h0000_0000;
   assign i_resp_err   = i_resp_valid && err_r;
   assign d_resp_valid = active_s && (state_r == RESP) && (owner_r == DATA);
   assign d_resp_rdata = d_resp_valid ? data_r : 32'h0000_0000;
   assign d_resp_err   = d_resp_valid && err_r;

   // Strobes are gated by reset so an access cut off mid-flight never lands.
   assign mem_read_enable  = active_s && (state_r == RD_ISSUE);
   assign mem_addr_read    = mem_read_enable ? addr_r[ADDR_W+1:2] : {ADDR_W{1'b0}};
   assign mem_write_enable = active_s && (state_r == WRITE);
   assign mem_addr_write   = mem_write_enable ? addr_r[ADDR_W+1:2] : {ADDR_W{1'b0}};
   assign mem_data_in      = !mem_write_enable ? 32'h0000_0000 :
                             (is_word_store(we_r, funct3_r) ? wdata_r : data_r);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, arbitration
// and reset-in-write sequences, and random traffic against a memory model.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   localparam int DEPTH  = 128;
   localparam int ADDR_W = 7;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              preload = 1'b1;
   logic              i_req_valid = 1'b0;
   logic [31:0]       i_req_addr = 32'h0;
   logic              i_req_ready, i_resp_valid, i_resp_err;
   logic [31:0]       i_resp_data;
   logic              d_req_valid = 1'b0, d_req_we = 1'b0;
   logic [31:0]       d_req_addr = 32'h0, d_req_wdata = 32'h0;
   logic [2:0]        d_req_funct3 = 3'b0;
   logic              d_req_ready, d_resp_valid, d_resp_err;
   logic [31:0]       d_resp_rdata;
   logic              mem_read_enable, mem_write_enable;
   logic [ADDR_W-1:0] mem_addr_read, mem_addr_write;
   logic [31:0]       mem_data_in;
   logic [31:0]       mem_data_out;

   logic [31:0]       bram    [DEPTH];
   logic [31:0]       ref_mem [DEPTH];
   int                total = 0;
   int                bad = 0;

   always #5 clock = ~clock;

   mem_access_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_funct3(d_req_funct3), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
      .mem_read_enable(mem_read_enable), .mem_addr_read(mem_addr_read),
      .mem_write_enable(mem_write_enable), .mem_addr_write(mem_addr_write),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h800080F0;
      return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
   endfunction

   // Simple-dual-port BRAM with one-cycle read latency.
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
      end else begin
         if (mem_write_enable) bram[mem_addr_write] <= mem_data_in;
         if (mem_read_enable) mem_data_out <= bram[mem_addr_read];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference behaviour: byte-addressed memory, wrapping at DEPTH*4 bytes.
   task automatic model(input bit is_fetch, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output int lat, output logic [31:0] data, output bit err,
                        output int nwr, output int nrd);
      int unsigned a, idx, off, size;
      bit sgn, legal;
      logic [31:0] w, v, mask;
      a = addr; idx = (a / 4) % DEPTH; off = a % 4;
      size = 1; sgn = 0; legal = 1;
      if (is_fetch) size = 4;
      else if (we) begin
         legal = (f3 <= 3'd2);
         if (legal) size = 1 << f3;
      end else begin
         case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: legal = 0;
         endcase
      end
      err = !legal || (off % size != 0);
      data = 32'h0; nwr = 0; nrd = 0; lat = 1;
      if (err) return;
      w = ref_mem[idx];
      if (is_fetch || !we) begin
         v = w >> (8 * off);
         if (size == 1) v = v & 32'hFF;
         if (size == 2) v = v & 32'hFFFF;
         if (sgn && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
         data = v; lat = 3; nrd = 1;
      end else if (size == 4) begin
         ref_mem[idx] = wdata; lat = 2; nwr = 1;
      end else begin
         mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
         ref_mem[idx] = (w & ~mask) | ((wdata << (8 * off)) & mask);
         lat = 4; nwr = 1; nrd = 1;
      end
   endtask

   // Issue one request on one port and observe it until its response.
   task automatic run_req(input bit is_fetch, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          output int lat, output logic [31:0] data, output bit err,
                          output int nwr, output int nrd, output bit ready_ok);
      int n;
      lat = -1; data = 32'h0; err = 0; nwr = 0; nrd = 0; ready_ok = 1;
      @(negedge clock);
      if (is_fetch) begin
         i_req_valid = 1'b1; i_req_addr = addr;
      end else begin
         d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr;
         d_req_wdata = wdata; d_req_funct3 = f3;
      end
      #1;
      n = 0;
      while (!(is_fetch ? i_req_ready : d_req_ready) && n < 20) begin
         @(negedge clock); #1; n++;
      end
      if (n >= 20) begin
         ready_ok = 0; i_req_valid = 1'b0; d_req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      @(negedge clock);
      for (int c = 1; c <= 12; c++) begin
         nwr += int'(mem_write_enable);
         nrd += int'(mem_read_enable);
         if (is_fetch ? i_req_ready : d_req_ready) ready_ok = 0;
         if (is_fetch ? i_resp_valid : d_resp_valid) begin
            lat = c;
            data = is_fetch ? i_resp_data : d_resp_rdata;
            err = is_fetch ? i_resp_err : d_resp_err;
            break;
         end
         @(negedge clock);
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
   endtask

   task automatic do_vec(input string name, input bit is_fetch, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                         input int e_lat, input logic [31:0] e_data, input bit e_err,
                         input int e_nwr, input int e_nrd);
      int lat, nwr, nrd;
      logic [31:0] data;
      bit err, rok;
      run_req(is_fetch, we, addr, wdata, f3, lat, data, err, nwr, nrd, rok);
      check({name, "_lat"}, 32'(lat), 32'(e_lat));
      check({name, "_data"}, data, e_data);
      check({name, "_err"}, 32'(err), 32'(e_err));
      check({name, "_writes"}, 32'(nwr), 32'(e_nwr));
      check({name, "_reads"}, 32'(nrd), 32'(e_nrd));
      check({name, "_ready_busy"}, 32'(rok), 32'd1);
   endtask

   task automatic check_quiet(input string name);
      check({name, "_flags"}, 32'({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid,
             i_resp_err, d_resp_err, mem_read_enable, mem_write_enable}), 32'h0);
      check({name, "_buses"}, i_resp_data | d_resp_rdata | mem_data_in |
             32'(mem_addr_read) | 32'(mem_addr_write), 32'h0);
   endtask

   typedef struct {
      bit          is_fetch;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          lat;
      logic [31:0] data;
      bit          err;
      int          nwr;
      int          nrd;
   } vec_t;

   vec_t vecs [18];

   initial begin
      int lat, nwr, nrd, n;
      logic [31:0] data, exp_d;
      bit err, exp_fetch;

      vecs[0]  = '{1, 0, 32'h10,  32'h0,        F3_W,  3, 32'h800080F0, 0, 0, 1};
      vecs[1]  = '{0, 0, 32'h10,  32'h0,        F3_B,  3, 32'hFFFFFFF0, 0, 0, 1};
      vecs[2]  = '{0, 0, 32'h11,  32'h0,        F3_BU, 3, 32'h00000080, 0, 0, 1};
      vecs[3]  = '{0, 0, 32'h12,  32'h0,        F3_H,  3, 32'hFFFF8000, 0, 0, 1};
      vecs[4]  = '{0, 0, 32'h12,  32'h0,        F3_HU, 3, 32'h00008000, 0, 0, 1};
      vecs[5]  = '{0, 0, 32'h10,  32'h0,        F3_W,  3, 32'h800080F0, 0, 0, 1};
      vecs[6]  = '{0, 1, 32'h13,  32'h000000AB, F3_B,  4, 32'h0,        0, 1, 1};
      vecs[7]  = '{0, 0, 32'h10,  32'h0,        F3_W,  3, 32'hAB0080F0, 0, 0, 1};
      vecs[8]  = '{0, 1, 32'h14,  32'h12345678, F3_W,  2, 32'h0,        0, 1, 0};
      vecs[9]  = '{0, 0, 32'h14,  32'h0,        F3_W,  3, 32'h12345678, 0, 0, 1};
      vecs[10] = '{0, 0, 32'h16,  32'h0,        F3_HU, 3, 32'h00001234, 0, 0, 1};
      vecs[11] = '{0, 0, 32'h12,  32'h0,        F3_W,  1, 32'h0,        1, 0, 0};
      vecs[12] = '{0, 1, 32'h11,  32'h0000BEEF, F3_H,  1, 32'h0,        1, 0, 0};
      vecs[13] = '{0, 0, 32'h10,  32'h0,        F3_W,  3, 32'hAB0080F0, 0, 0, 1};
      vecs[14] = '{0, 0, 32'h10,  32'h0,        3'd3,  1, 32'h0,        1, 0, 0};
      vecs[15] = '{0, 1, 32'h10,  32'h0,        3'd4,  1, 32'h0,        1, 0, 0};
      vecs[16] = '{1, 0, 32'h02,  32'h0,        F3_W,  1, 32'h0,        1, 0, 0};
      vecs[17] = '{0, 0, 32'h213, 32'h0,        F3_B,  3, 32'hFFFFFFAB, 0, 0, 1};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

      // Reset: requests are ignored and every output reads zero.
      i_req_valid = 1'b1; d_req_valid = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_quiet("reset_hold");
      i_req_valid = 1'b0; d_req_valid = 1'b0; preload = 1'b0; reset = 1'b0;
      #1;
      check_quiet("reset_release");

      // Arbitration with both ports held valid: fetch, data, fetch, data.
      @(negedge clock);
      i_req_valid = 1'b1; i_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h10; d_req_funct3 = F3_W;
      exp_fetch = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (!(i_req_ready || d_req_ready) && n < 20) begin
            @(negedge clock); #1; n++;
         end
         check("arb_first_idle", 32'(n), 32'd0);
         check("arb_fetch_ready", 32'(i_req_ready), 32'(exp_fetch));
         check("arb_data_ready", 32'(d_req_ready), 32'(!exp_fetch));
         @(posedge clock);
         @(negedge clock);
         lat = -1;
         for (int c = 1; c <= 10; c++) begin
            if (exp_fetch ? i_resp_valid : d_resp_valid) begin
               lat = c; break;
            end
            @(negedge clock);
         end
         exp_d = exp_fetch ? ref_mem[0] : ref_mem[4];
         check("arb_lat", 32'(lat), 32'd3);
         check("arb_data", exp_fetch ? i_resp_data : d_resp_rdata, exp_d);
         exp_fetch = !exp_fetch;
         if (k < 3) @(negedge clock);
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;

      // Reset landing in the WRITE cycle of a byte store.
      @(negedge clock);
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h10;
      d_req_wdata = 32'h00000055; d_req_funct3 = F3_B;
      #1;
      check("rst_accept", 32'(d_req_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      d_req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_pre_write", 32'(mem_write_enable), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_write_gated", 32'(mem_write_enable), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_quiet("rst_after");
      n = 0;
      repeat (5) begin
         @(negedge clock);
         n += int'(i_resp_valid) + int'(d_resp_valid) + int'(mem_write_enable);
      end
      check("rst_no_resp", 32'(n), 32'd0);
      do_vec("rst_word", 0, 0, 32'h10, 32'h0, F3_W, 3, 32'h800080F0, 0, 0, 1);

      // Directed vectors; the model is kept in step with the stores.
      for (int i = 0; i < 18; i++) begin
         model(vecs[i].is_fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
               lat, data, err, nwr, nrd);
         do_vec($sformatf("vec%0d", i), vecs[i].is_fetch, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].f3, vecs[i].lat, vecs[i].data, vecs[i].err,
                vecs[i].nwr, vecs[i].nrd);
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 200; i++) begin
         bit          rf, rw;
         logic [31:0] ra, rd;
         logic [2:0]  rf3;
         rf  = 1'($urandom_range(0, 1));
         rw  = 1'($urandom_range(0, 1));
         ra  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) ra = ra | ($urandom() & 32'hFFFFFE00);
         rd  = $urandom();
         rf3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 4) != 0) begin
            case ($urandom_range(0, 4))
               0: rf3 = F3_B;
               1: rf3 = F3_H;
               2: rf3 = F3_W;
               3: rf3 = F3_BU;
               default: rf3 = F3_HU;
            endcase
         end
         model(rf, rw, ra, rd, rf3, lat, data, err, nwr, nrd);
         do_vec($sformatf("rnd%0d", i), rf, rw, ra, rd, rf3, lat, data, err, nwr, nrd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
